imem_axil_loader: RTL and testbench

- AXI4-Lite slave that lets the host load and read back the 16 KB instruction BRAM through that memory's host-side port (write enable, 12-bit word address, write data, registered read data).
- Also holds a one-bit control register that keeps the CPU in reset while a program is loaded.
- Sits between the SoC AXI interconnect and the instruction memory's host port. The CPU fetch port is not touched.

---
 rtl/imem_loader_pkg.sv | 40 ++++
 rtl/imem_axil_loader.sv | 208 ++++++++++++++++++++
 tb/tb_imem_axil_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory AXI4-Lite loader.
// Holds the controller state encoding, AXI response codes, the address map
// and the address-decode helper used by both the read and write paths.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EXEC,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RD_RESP
  } state_e;

  typedef enum logic [1:0] {
    RGN_MEM,
    RGN_CTRL,
    RGN_ERR
  } region_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] CTRL_ADDR   = 16'h4000;
  localparam logic [31:0] MEM_LIMIT   = 32'h0000_4000;

  // Byte-address decode; the two low address bits are don't-care.
  function automatic region_e decode_addr(input logic [31:0] addr,
                                          input logic [31:0] ctrl_addr);
    region_e rgn;
    if ({addr[31:2], 2'b00} < MEM_LIMIT) begin
      rgn = RGN_MEM;
    end else if (addr[31:2] == ctrl_addr[31:2]) begin
      rgn = RGN_CTRL;
    end else begin
      rgn = RGN_ERR;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/imem_axil_loader.sv
// AXI4-Lite slave giving the host load/read-back access to the instruction
// BRAM through its host-side port, plus a one-bit control register that
// holds the CPU in reset while a program is loaded.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*    AXI4-Lite write address, data and response channels
//   s_axil_ar*/r*       AXI4-Lite read address and data channels
//   mem_we              BRAM write enable (single-cycle pulse)
//   mem_addr            BRAM word address
//   mem_wdata           BRAM write data
//   mem_rdata           BRAM registered read data (one cycle after mem_addr)
//   cpu_rst_hold        control bit 0; 1 keeps the CPU in reset
module imem_axil_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          MEM_AW    = 12,
  parameter logic [15:0] CTRL_ADDR = imem_loader_pkg::CTRL_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_rst_hold
);

  import imem_loader_pkg::*;

  localparam logic [31:0] CTRL_ADDR_EXT = 32'(CTRL_ADDR);

  state_e            state_q;
  logic              rdy_en_q;
  logic              aw_held_q;
  logic              w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              prio_rd_q;
  logic              wr_err_q;
  region_e           rd_rgn_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q;
  logic              hold_q;

  logic    wr_ready;
  logic    aw_fire;
  logic    w_fire;
  logic    ar_fire;
  region_e wr_rgn;
  region_e ar_rgn;
  logic    wr_err;
  logic    wr_mem_ok;

  // rdy_en_q keeps every ready low while reset is asserted, since the held
  // flags alone would otherwise advertise ready during reset.
  assign s_axil_awready = rdy_en_q & ~aw_held_q;
  assign s_axil_wready  = rdy_en_q & ~w_held_q;
  assign wr_ready       = aw_held_q & w_held_q;
  assign s_axil_arready = rdy_en_q && (state_q == ST_IDLE) && (!wr_ready || prio_rd_q);

  assign aw_fire = s_axil_awvalid & s_axil_awready;
  assign w_fire  = s_axil_wvalid & s_axil_wready;
  assign ar_fire = s_axil_arvalid & s_axil_arready;

  assign wr_rgn    = decode_addr(32'(awaddr_q), CTRL_ADDR_EXT);
  assign ar_rgn    = decode_addr(32'(s_axil_araddr), CTRL_ADDR_EXT);
  // The BRAM has no byte enables, so only full-word memory writes are legal.
  assign wr_mem_ok = (wr_rgn == RGN_MEM) && (wstrb_q == 4'hF);
  assign wr_err    = (wr_rgn == RGN_ERR) || ((wr_rgn == RGN_MEM) && !wr_mem_ok);

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_rst_hold  = hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prio_rd_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_rgn_q    <= RGN_MEM;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      hold_q      <= 1'b1;
    end else begin
      rdy_en_q <= 1'b1;
      mem_we_q <= 1'b0;

      // AW and W are captured independently, in any order.
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr;
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end

      case (state_q)
        ST_IDLE: begin
          if (ar_fire) begin
            // A read only wins a tie when the flag selects read; hand the
            // next tie to the write.
            if (wr_ready) prio_rd_q <= 1'b0;
            rd_rgn_q <= ar_rgn;
            if (ar_rgn == RGN_MEM) mem_addr_q <= s_axil_araddr[MEM_AW+1:2];
            state_q <= ST_RD_ADDR;
          end else if (wr_ready) begin
            if (s_axil_arvalid) prio_rd_q <= 1'b1;
            wr_err_q <= wr_err;
            if (wr_mem_ok) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= awaddr_q[MEM_AW+1:2];
              mem_wdata_q <= wdata_q;
            end
            state_q <= ST_WR_EXEC;
          end
        end
        ST_WR_EXEC: begin
          if ((wr_rgn == RGN_CTRL) && wstrb_q[0]) hold_q <= wdata_q[0];
          bvalid_q <= 1'b1;
          bresp_q  <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
          state_q  <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (s_axil_bready) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        // mem_addr is on the port this cycle; the BRAM samples it at the edge.
        ST_RD_ADDR: begin
          state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          rvalid_q <= 1'b1;
          case (rd_rgn_q)
            RGN_MEM: begin
              rdata_q <= mem_rdata;
              rresp_q <= RESP_OKAY;
            end
            RGN_CTRL: begin
              rdata_q <= {31'b0, hold_q};
              rresp_q <= RESP_OKAY;
            end
            default: begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          endcase
          state_q <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (s_axil_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_axil_loader.sv
// Directed bench for imem_axil_loader with a registered-read BRAM model.
module tb_imem_axil_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_rst_hold;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram [0:4095];
  int          we_cnt = 0;
  logic [11:0] we_addr = '0;
  logic [31:0] we_data = '0;

  always #5 clk = ~clk;

  imem_axil_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready), .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready), .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_rst_hold(cpu_rst_hold)
  );

  // Instruction BRAM model: write port plus one-cycle registered read.
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_ch(input logic do_aw, input logic do_w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done, af, wf;
    aw_done = !do_aw;
    w_done  = !do_w;
    if (do_aw) begin awaddr = a; awvalid = 1'b1; end
    if (do_w) begin wdata = d; wstrb = s; wvalid = 1'b1; end
    for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
      @(negedge clk);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk);
      #1;
      if (af) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (wf) begin wvalid = 1'b0; w_done = 1'b1; end
    end
    chk("aw_w_handshake_timeout", 32'(!(aw_done && w_done)), 32'd0);
  endtask

  task automatic get_b(output logic [1:0] r);
    for (int n = 0; n < 50 && !bvalid; n++) tick();
    chk("bvalid_timeout", 32'(bvalid), 32'd1);
    r = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_ar(input logic [15:0] a, output int lat);
    logic ok;
    ok = 1'b0;
    araddr = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = arready;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    chk("ar_handshake_timeout", 32'(ok), 32'd1);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic get_r(output logic [31:0] d, output logic [1:0] r);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r);
    put_ch(1'b1, 1'b1, a, d, s);
    get_b(r);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r,
                    output int lat);
    do_ar(a, lat);
    get_r(d, r);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] d0;
    int          lat;
    int          c0;
    int          t_b;
    int          t_r;
    logic        af;

    // Reset state.
    repeat (3) tick();
    chk("reset_valids_readys", 32'({awready, wready, arready, bvalid, rvalid, mem_we}), 32'd0);
    chk("reset_resp", 32'({bresp, rresp}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_cpu_rst_hold", 32'(cpu_rst_hold), 32'd1);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_readys", 32'({awready, wready, arready}), 32'h7);

    // Control register after reset.
    rd(16'h4000, d, r, lat);
    chk("ctrl_rd_reset_val", d, 32'd1);
    chk("ctrl_rd_reset_resp", 32'(r), 32'(RESP_OKAY));
    chk("ctrl_hold_after_reset", 32'(cpu_rst_hold), 32'd1);

    // Write then read back, AW and W in the same cycle.
    c0 = we_cnt;
    wr(16'h0010, 32'hDEADBEEF, 4'hF, r);
    chk("wr1_bresp", 32'(r), 32'(RESP_OKAY));
    chk("wr1_we_pulses", 32'(we_cnt - c0), 32'd1);
    chk("wr1_we_addr", 32'(we_addr), 32'h4);
    chk("wr1_we_data", we_data, 32'hDEADBEEF);
    rd(16'h0010, d, r, lat);
    chk("rd1_latency", 32'(lat), 32'd2);
    chk("rd1_rdata", d, 32'hDEADBEEF);
    chk("rd1_rresp", 32'(r), 32'(RESP_OKAY));

    // W three cycles ahead of AW.
    c0 = we_cnt;
    put_ch(1'b0, 1'b1, 16'h0, 32'h12345678, 4'hF);
    repeat (3) tick();
    chk("w_only_no_we", 32'(we_cnt - c0), 32'd0);
    put_ch(1'b1, 1'b0, 16'h3FFC, 32'h0, 4'h0);
    get_b(r);
    chk("wr2_bresp", 32'(r), 32'(RESP_OKAY));
    chk("wr2_we_pulses", 32'(we_cnt - c0), 32'd1);
    chk("wr2_we_addr", 32'(we_addr), 32'hFFF);
    rd(16'h3FFC, d, r, lat);
    chk("rd2_rdata", d, 32'h12345678);

    // Partial strobe to memory.
    wr(16'h0020, 32'hCAFEF00D, 4'hF, r);
    c0 = we_cnt;
    wr(16'h0020, 32'hAAAA5555, 4'b0011, r);
    chk("partial_bresp", 32'(r), 32'(RESP_SLVERR));
    chk("partial_no_we", 32'(we_cnt - c0), 32'd0);
    rd(16'h0020, d, r, lat);
    chk("partial_rd_prior", d, 32'hCAFEF00D);

    // Control register write and unmapped accesses.
    wr(16'h4000, 32'h0, 4'hF, r);
    chk("ctrl_wr_bresp", 32'(r), 32'(RESP_OKAY));
    chk("ctrl_hold_cleared", 32'(cpu_rst_hold), 32'd0);
    rd(16'h4000, d, r, lat);
    chk("ctrl_rd_zero", d, 32'd0);
    rd(16'h4004, d, r, lat);
    chk("unmapped_rd_resp", 32'(r), 32'(RESP_SLVERR));
    chk("unmapped_rd_data", d, 32'd0);
    c0 = we_cnt;
    wr(16'h4004, 32'h1, 4'hF, r);
    chk("unmapped_wr_resp", 32'(r), 32'(RESP_SLVERR));
    chk("unmapped_wr_no_side_effect", 32'({cpu_rst_hold, 8'(we_cnt - c0)}), 32'd0);

    // Write response backpressure with a second AW waiting.
    put_ch(1'b1, 1'b1, 16'h0040, 32'h0BADF00D, 4'hF);
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    awaddr = 16'h0044;
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid_held", 32'(bvalid), 32'd1);
      chk("bp_bresp_stable", 32'(bresp), 32'(RESP_OKAY));
      chk("bp_second_aw_blocked", 32'(awready), 32'd0);
      @(posedge clk);
      #1;
    end
    get_b(r);
    put_ch(1'b1, 1'b1, 16'h0044, 32'h01020304, 4'hF);
    get_b(r);
    chk("bp_second_wr_bresp", 32'(r), 32'(RESP_OKAY));

    // Read data backpressure with a second AR waiting.
    do_ar(16'h0044, lat);
    d0 = rdata;
    chk("rbp_first_rdata", d0, 32'h01020304);
    araddr = 16'h0040;
    arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rbp_rvalid_held", 32'(rvalid), 32'd1);
      chk("rbp_rdata_stable", rdata, d0);
      chk("rbp_second_ar_blocked", 32'(arready), 32'd0);
      @(posedge clk);
      #1;
    end
    get_r(d, r);
    rd(16'h0040, d, r, lat);
    chk("rbp_second_rdata", d, 32'h0BADF00D);

    // Arbitration: write and read both pending in IDLE, twice.
    for (int round = 0; round < 2; round++) begin
      do_ar(16'h0010, lat);
      put_ch(1'b1, 1'b1, 16'h0080, 32'h80808080 + 32'(round), 4'hF);
      araddr = 16'h0010;
      arvalid = 1'b1;
      get_r(d, r);
      t_b = -1;
      t_r = -1;
      d = '0;
      bready = 1'b1;
      rready = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        af = arvalid && arready;
        @(posedge clk);
        #1;
        if (af) arvalid = 1'b0;
        if (bvalid && t_b < 0) t_b = c;
        if (rvalid && t_r < 0) begin
          t_r = c;
          d = rdata;
        end
      end
      bready = 1'b0;
      rready = 1'b0;
      chk("arb_both_served", 32'({t_b >= 0, t_r >= 0}), 32'h3);
      chk(round == 0 ? "arb_round1_write_first" : "arb_round2_read_first",
          32'(t_b < t_r), round == 0 ? 32'd1 : 32'd0);
      chk("arb_read_data", d, 32'hDEADBEEF);
    end

    // Reset while the read is in RD_DATA.
    chk("pre_reset_hold_low", 32'(cpu_rst_hold), 32'd0);
    araddr = 16'h0010;
    arvalid = 1'b1;
    af = 1'b0;
    for (int n = 0; n < 20 && !af; n++) begin
      @(negedge clk);
      af = arready;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_valids", 32'({rvalid, bvalid, mem_we}), 32'd0);
    chk("rst_rd_hold", 32'(cpu_rst_hold), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_rd_no_leftover_rvalid", 32'(rvalid), 32'd0);
    rd(16'h0010, d, r, lat);
    chk("post_rst_rd_latency", 32'(lat), 32'd2);
    chk("post_rst_rd_data", d, 32'hDEADBEEF);

    // Reset in the cycle before WR_EXEC.
    wr(16'h4000, 32'h0, 4'hF, r);
    wr(16'h0100, 32'h11112222, 4'hF, r);
    c0 = we_cnt;
    put_ch(1'b1, 1'b1, 16'h0100, 32'h55AA55AA, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_valids", 32'({bvalid, mem_we, awready, wready}), 32'd0);
    chk("rst_wr_hold", 32'(cpu_rst_hold), 32'd1);
    tick();
    tick();
    chk("rst_wr_no_we", 32'(we_cnt - c0), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    rd(16'h0100, d, r, lat);
    chk("rst_wr_mem_unchanged", d, 32'h11112222);
    wr(16'h0104, 32'h77777777, 4'hF, r);
    chk("post_rst_wr_bresp", 32'(r), 32'(RESP_OKAY));
    chk("post_rst_wr_we", 32'(we_cnt - c0), 32'd1);
    rd(16'h0104, d, r, lat);
    chk("post_rst_wr_readback", d, 32'h77777777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
